id_ex_stage: RTL and testbench



---
 rtl/id_ex_stage_pkg.sv | 47 ++++
 rtl/id_ex_stage_if.sv | 49 ++++
 rtl/id_ex_stage_hazard_detect.sv | 52 +++++
 rtl/id_ex_stage.sv | 113 +++++++++++
 tb/tb_id_ex_stage.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX boundary: control-bundle layout,
// write-back select encodings and the RV32 opcodes used for operand-use decode.
package id_ex_stage_pkg;

  // Control bundle, MSB first:
  // RegWrite, MemWrite, ALUOp[4:0], ALUSrc, DMType[2:0], WDSel[1:0],
  // IsBranch, IsJAL, IsJALR, CSRWrite, CSRRead, CSROp[2:0], IsCSR, IsMRET
  localparam int CTRL_W = 23;

  localparam int CTRL_REGWRITE  = 22;
  localparam int CTRL_MEMWRITE  = 21;
  localparam int CTRL_ALUOP_LSB = 16;
  localparam int CTRL_ALUSRC    = 15;
  localparam int CTRL_DMTYPE_LSB = 12;
  localparam int CTRL_WDSEL_LSB = 10;
  localparam int CTRL_ISBRANCH  = 9;
  localparam int CTRL_ISJAL     = 8;
  localparam int CTRL_ISJALR    = 7;
  localparam int CTRL_CSRWRITE  = 6;
  localparam int CTRL_CSRREAD   = 5;
  localparam int CTRL_CSROP_LSB = 2;
  localparam int CTRL_ISCSR     = 1;
  localparam int CTRL_ISMRET    = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;

  // Write-back sources whose data is not available until after EX
  localparam logic [1:0] WDSEL_MEM = 2'b01;
  localparam logic [1:0] WDSEL_CSR = 2'b11;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] CSR_OPCODE = 7'b1110011;

  // Write-back select field of a control bundle
  function automatic logic [1:0] ctrl_wdsel(input ctrl_t c);
    return c[CTRL_WDSEL_LSB +: 2];
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between the decoder/hazard environment and the ID/EX stage.
// master drives the ID side and the EX hold/flush; slave is the stage itself.
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
);
  logic              id_valid;
  logic [6:0]        id_op;
  logic [2:0]        id_funct3;
  ctrl_t             id_ctrl;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic [CSR_AW-1:0] id_csr_addr;
  logic              ex_hold;
  logic              ex_flush;

  logic              hz_stall;
  logic              ex_valid;
  ctrl_t             ex_ctrl;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_rs1_data;
  logic [XLEN-1:0]   ex_rs2_data;
  logic [XLEN-1:0]   ex_imm;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic [CSR_AW-1:0] ex_csr_addr;

  modport master (
    output id_valid, id_op, id_funct3, id_ctrl, id_pc, id_rs1_data, id_rs2_data,
           id_imm, id_rs1, id_rs2, id_rd, id_csr_addr, ex_hold, ex_flush,
    input  hz_stall, ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_csr_addr
  );

  modport slave (
    input  id_valid, id_op, id_funct3, id_ctrl, id_pc, id_rs1_data, id_rs2_data,
           id_imm, id_rs1, id_rs2, id_rd, id_csr_addr, ex_hold, ex_flush,
    output hz_stall, ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_csr_addr
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use / CSR-use hazard detection between the ID instruction and the
// instruction currently in EX. Purely combinational.
module id_ex_stage_hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic       id_valid_i,
  input  logic [6:0] id_op_i,
  input  logic       id_csr_uimm_i,   // funct3[2]: CSR immediate form, rs1 field is a uimm
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       ex_valid_i,
  input  logic       ex_regwrite_i,
  input  logic [1:0] ex_wdsel_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_hold_i,
  input  logic       ex_flush_i,
  output logic       hz_o,
  output logic       hz_stall_o
);

  logic use_rs1;
  logic use_rs2;
  logic ex_late_wb;
  logic rs1_match;
  logic rs2_match;

  // Decode which source registers the ID instruction actually reads
  always_comb begin
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    case (id_op_i)
      OP_LUI, OP_AUIPC, OP_JAL: use_rs1 = 1'b0;
      CSR_OPCODE:               use_rs1 = !id_csr_uimm_i;
      default:                  ;
    endcase
    if (id_op_i == OP_OP || id_op_i == OP_STORE || id_op_i == OP_BRANCH) begin
      use_rs2 = 1'b1;
    end
  end

  // EX result only exists after the memory/CSR access, so it cannot be forwarded yet
  assign ex_late_wb = (ex_wdsel_i == WDSEL_MEM) || (ex_wdsel_i == WDSEL_CSR);
  assign rs1_match  = use_rs1 && (id_rs1_i == ex_rd_i);
  assign rs2_match  = use_rs2 && (id_rs2_i == ex_rd_i);

  assign hz_o = ex_valid_i && id_valid_i && ex_regwrite_i && (ex_rd_i != 5'd0) &&
                ex_late_wb && (rs1_match || rs2_match);

  // A flushed or held EX makes the front-end stall pointless this cycle
  assign hz_stall_o = hz_o && !ex_flush_i && !ex_hold_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RV32 core: latches the decoded instruction,
// inserts bubbles for hazards/flushes and honours the downstream hold.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic clk,
  input  logic rstn,
  id_ex_stage_if.slave bus
);

  logic              ex_valid_q,    ex_valid_d;
  ctrl_t             ex_ctrl_q,     ex_ctrl_d;
  logic [XLEN-1:0]   ex_pc_q,       ex_pc_d;
  logic [XLEN-1:0]   ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0]   ex_rs2_data_q, ex_rs2_data_d;
  logic [XLEN-1:0]   ex_imm_q,      ex_imm_d;
  logic [4:0]        ex_rs1_q,      ex_rs1_d;
  logic [4:0]        ex_rs2_q,      ex_rs2_d;
  logic [4:0]        ex_rd_q,       ex_rd_d;
  logic [CSR_AW-1:0] ex_csr_addr_q, ex_csr_addr_d;

  logic hz;

  id_ex_stage_hazard_detect u_hazard (
    .id_valid_i    (bus.id_valid),
    .id_op_i       (bus.id_op),
    .id_csr_uimm_i (bus.id_funct3[2]),
    .id_rs1_i      (bus.id_rs1),
    .id_rs2_i      (bus.id_rs2),
    .ex_valid_i    (ex_valid_q),
    .ex_regwrite_i (ex_ctrl_q[CTRL_REGWRITE]),
    .ex_wdsel_i    (ctrl_wdsel(ex_ctrl_q)),
    .ex_rd_i       (ex_rd_q),
    .ex_hold_i     (bus.ex_hold),
    .ex_flush_i    (bus.ex_flush),
    .hz_o          (hz),
    .hz_stall_o    (bus.hz_stall)
  );

  // Next EX contents: hold > flush > hazard > empty ID > load.
  // Bubbles clear only valid and control; datapath keeps its old value.
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_ctrl_d     = ex_ctrl_q;
    ex_pc_d       = ex_pc_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_imm_d      = ex_imm_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_rd_d       = ex_rd_q;
    ex_csr_addr_d = ex_csr_addr_q;
    if (!bus.ex_hold) begin
      if (bus.ex_flush || hz || !bus.id_valid) begin
        ex_valid_d = 1'b0;
        ex_ctrl_d  = '0;
      end else begin
        ex_valid_d    = 1'b1;
        ex_ctrl_d     = bus.id_ctrl;
        ex_pc_d       = bus.id_pc;
        ex_rs1_data_d = bus.id_rs1_data;
        ex_rs2_data_d = bus.id_rs2_data;
        ex_imm_d      = bus.id_imm;
        ex_rs1_d      = bus.id_rs1;
        ex_rs2_d      = bus.id_rs2;
        ex_rd_d       = bus.id_rd;
        ex_csr_addr_d = bus.id_csr_addr;
      end
    end
  end

  // EX-stage registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ex_valid_q    <= 1'b0;
      ex_ctrl_q     <= '0;
      ex_pc_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_csr_addr_q <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_csr_addr_q <= ex_csr_addr_d;
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_ctrl     = ex_ctrl_q;
  assign bus.ex_pc       = ex_pc_q;
  assign bus.ex_rs1_data = ex_rs1_data_q;
  assign bus.ex_rs2_data = ex_rs2_data_q;
  assign bus.ex_imm      = ex_imm_q;
  assign bus.ex_rs1      = ex_rs1_q;
  assign bus.ex_rs2      = ex_rs2_q;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.ex_csr_addr = ex_csr_addr_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven bench for id_ex_stage with a one-deep expected-result queue.
module tb_id_ex_stage;

  localparam int CW = id_ex_stage_pkg::CTRL_W;

  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_OPIMM  = 7'b0010011;
  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_SYS    = 7'b1110011;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32), .CSR_AW(12)) bus ();

  id_ex_stage #(.XLEN(32), .CSR_AW(12)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic          vld;
    logic [6:0]    op;
    logic [2:0]    f3;
    logic [CW-1:0] ctrl;
    logic [31:0]   pc;
    logic [4:0]    rs1, rs2, rd;
    logic          hold, flush;
    logic          exp_stall;
    logic          exp_vld;
    logic [CW-1:0] exp_ctrl;
    logic [31:0]   exp_pc;
    logic [4:0]    exp_rs1, exp_rs2, exp_rd;
  } vec_t;

  typedef struct {
    logic          vld;
    logic [CW-1:0] ctrl;
    logic [31:0]   pc;
    logic [4:0]    rs1, rs2, rd;
    int            idx;
  } sb_t;

  vec_t vt[$];
  sb_t  sb[$];

  // Control bundle built field by field in the documented order
  function automatic logic [CW-1:0] mk(input logic rw, input logic mw, input logic [4:0] aluop,
                                       input logic alusrc, input logic [2:0] dmt, input logic [1:0] wds,
                                       input logic br, input logic jal, input logic jalr,
                                       input logic csrw, input logic csrr, input logic [2:0] csrop,
                                       input logic iscsr, input logic mret);
    return {rw, mw, aluop, alusrc, dmt, wds, br, jal, jalr, csrw, csrr, csrop, iscsr, mret};
  endfunction

  // Datapath payloads are derived from the PC so each instruction is distinguishable
  function automatic logic [31:0] d_rs1(input logic [31:0] pc); return pc ^ 32'hA5A5_0000; endfunction
  function automatic logic [31:0] d_rs2(input logic [31:0] pc); return pc + 32'h0000_1000; endfunction
  function automatic logic [31:0] d_imm(input logic [31:0] pc); return {pc[15:0], 16'h0FF0}; endfunction
  function automatic logic [11:0] d_csr(input logic [31:0] pc); return pc[11:0] ^ 12'h300; endfunction

  function automatic vec_t mkv(input logic vld, input logic [6:0] op, input logic [2:0] f3,
                               input logic [CW-1:0] ctrl, input logic [31:0] pc,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic hold, input logic flush, input logic exp_stall,
                               input logic exp_vld, input logic [CW-1:0] exp_ctrl, input logic [31:0] exp_pc,
                               input logic [4:0] exp_rs1, input logic [4:0] exp_rs2, input logic [4:0] exp_rd);
    vec_t v;
    v.vld = vld; v.op = op; v.f3 = f3; v.ctrl = ctrl; v.pc = pc;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.hold = hold; v.flush = flush;
    v.exp_stall = exp_stall; v.exp_vld = exp_vld; v.exp_ctrl = exp_ctrl; v.exp_pc = exp_pc;
    v.exp_rs1 = exp_rs1; v.exp_rs2 = exp_rs2; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [6:0] op, input logic [2:0] f3,
                       input logic [CW-1:0] ctrl, input logic [31:0] pc,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic hold, input logic flush);
    bus.id_valid    = vld;
    bus.id_op       = op;
    bus.id_funct3   = f3;
    bus.id_ctrl     = ctrl;
    bus.id_pc       = pc;
    bus.id_rs1_data = d_rs1(pc);
    bus.id_rs2_data = d_rs2(pc);
    bus.id_imm      = d_imm(pc);
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rd       = rd;
    bus.id_csr_addr = d_csr(pc);
    bus.ex_hold     = hold;
    bus.ex_flush    = flush;
  endtask

  // Compare EX against the oldest queued expectation
  task automatic check_ex();
    sb_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
      return;
    end
    e = sb.pop_front();
    chk($sformatf("v%0d ex_valid", e.idx), 64'(bus.ex_valid), 64'(e.vld));
    chk($sformatf("v%0d ex_ctrl", e.idx), 64'(bus.ex_ctrl), 64'(e.ctrl));
    if (e.vld) begin
      chk($sformatf("v%0d ex_pc", e.idx), 64'(bus.ex_pc), 64'(e.pc));
      chk($sformatf("v%0d ex_rd", e.idx), 64'(bus.ex_rd), 64'(e.rd));
      chk($sformatf("v%0d ex_rs1", e.idx), 64'(bus.ex_rs1), 64'(e.rs1));
      chk($sformatf("v%0d ex_rs2", e.idx), 64'(bus.ex_rs2), 64'(e.rs2));
      chk($sformatf("v%0d ex_rs1_data", e.idx), 64'(bus.ex_rs1_data), 64'(d_rs1(e.pc)));
      chk($sformatf("v%0d ex_rs2_data", e.idx), 64'(bus.ex_rs2_data), 64'(d_rs2(e.pc)));
      chk($sformatf("v%0d ex_imm", e.idx), 64'(bus.ex_imm), 64'(d_imm(e.pc)));
      chk($sformatf("v%0d ex_csr_addr", e.idx), 64'(bus.ex_csr_addr), 64'(d_csr(e.pc)));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [CW-1:0] C_ADD, C_ADDI, C_LW, C_LUI, C_SW, C_BEQ, C_CSRRS, C_CSRRW, C_CSRRWI, Z;
    sb_t e;
    C_ADD    = mk(1, 0, 5'd1,  0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 0);
    C_ADDI   = mk(1, 0, 5'd1,  1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 0);
    C_LW     = mk(1, 0, 5'd1,  1, 3'b010, 2'b01, 0, 0, 0, 0, 0, 3'b000, 0, 0);
    C_LUI    = mk(1, 0, 5'd10, 1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 0);
    C_SW     = mk(0, 1, 5'd1,  1, 3'b010, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 0);
    C_BEQ    = mk(0, 0, 5'd2,  0, 3'b000, 2'b00, 1, 0, 0, 0, 0, 3'b000, 0, 0);
    C_CSRRS  = mk(1, 0, 5'd0,  0, 3'b000, 2'b11, 0, 0, 0, 0, 1, 3'b010, 1, 0);
    C_CSRRW  = mk(1, 0, 5'd0,  0, 3'b000, 2'b11, 0, 0, 0, 1, 1, 3'b001, 1, 0);
    C_CSRRWI = mk(1, 0, 5'd0,  0, 3'b000, 2'b11, 0, 0, 0, 1, 1, 3'b101, 1, 0);
    Z        = '0;

    //              vld op      f3      ctrl      pc        rs1 rs2 rd h  f | stall vld ctrl     pc        rs1 rs2 rd
    vt.push_back(mkv(1, T_OP,    3'b000, C_ADD,    32'h00,   1,  2,  3, 0, 0,  0,  1, C_ADD,    32'h00,   1,  2,  3));  // add x3,x1,x2
    vt.push_back(mkv(1, T_OPIMM, 3'b000, C_ADDI,   32'h04,   0,  5,  4, 0, 0,  0,  1, C_ADDI,   32'h04,   0,  5,  4));  // addi x4,x0,5
    vt.push_back(mkv(1, T_LOAD,  3'b010, C_LW,     32'h08,   1,  0,  5, 0, 0,  0,  1, C_LW,     32'h08,   1,  0,  5));  // lw x5
    vt.push_back(mkv(1, T_OP,    3'b000, C_ADD,    32'h0C,   5,  2,  6, 0, 0,  1,  0, Z,        32'h0,    0,  0,  0));  // add x6,x5,x2: stall
    vt.push_back(mkv(1, T_OP,    3'b000, C_ADD,    32'h0C,   5,  2,  6, 0, 0,  0,  1, C_ADD,    32'h0C,   5,  2,  6));  // stall released
    vt.push_back(mkv(1, T_LOAD,  3'b010, C_LW,     32'h10,   1,  0,  0, 0, 0,  0,  1, C_LW,     32'h10,   1,  0,  0));  // lw x0
    vt.push_back(mkv(1, T_OP,    3'b000, C_ADD,    32'h14,   0,  0,  7, 0, 0,  0,  1, C_ADD,    32'h14,   0,  0,  7));  // add x7,x0,x0
    vt.push_back(mkv(1, T_LOAD,  3'b010, C_LW,     32'h18,   1,  0,  5, 0, 0,  0,  1, C_LW,     32'h18,   1,  0,  5));  // lw x5
    vt.push_back(mkv(1, T_LUI,   3'b000, C_LUI,    32'h1C,   5,  5,  5, 0, 0,  0,  1, C_LUI,    32'h1C,   5,  5,  5));  // lui x5: fields unused
    vt.push_back(mkv(1, T_LOAD,  3'b010, C_LW,     32'h20,   1,  0,  5, 0, 0,  0,  1, C_LW,     32'h20,   1,  0,  5));  // lw x5
    vt.push_back(mkv(1, T_OP,    3'b000, C_ADD,    32'h24,   5,  5,  6, 0, 1,  0,  0, Z,        32'h0,    0,  0,  0));  // flush beats hazard
    vt.push_back(mkv(1, T_SYS,   3'b010, C_CSRRS,  32'h28,   0,  0,  9, 0, 0,  0,  1, C_CSRRS,  32'h28,   0,  0,  9));  // csrrs x9
    vt.push_back(mkv(1, T_OPIMM, 3'b000, C_ADDI,   32'h2C,   9,  0, 10, 0, 0,  1,  0, Z,        32'h0,    0,  0,  0));  // CSR-use stall
    vt.push_back(mkv(1, T_OPIMM, 3'b000, C_ADDI,   32'h2C,   9,  0, 10, 0, 0,  0,  1, C_ADDI,   32'h2C,   9,  0, 10));
    vt.push_back(mkv(1, T_LOAD,  3'b010, C_LW,     32'h30,   1,  0, 12, 0, 0,  0,  1, C_LW,     32'h30,   1,  0, 12));  // lw x12
    vt.push_back(mkv(1, T_SYS,   3'b101, C_CSRRWI, 32'h34,  12,  0, 13, 0, 0,  0,  1, C_CSRRWI, 32'h34,  12,  0, 13));  // csrrwi: uimm, no stall
    vt.push_back(mkv(1, T_LOAD,  3'b010, C_LW,     32'h38,   1,  0, 12, 0, 0,  0,  1, C_LW,     32'h38,   1,  0, 12));  // lw x12
    vt.push_back(mkv(1, T_SYS,   3'b001, C_CSRRW,  32'h3C,  12,  0, 13, 0, 0,  1,  0, Z,        32'h0,    0,  0,  0));  // csrrw reads x12: stall
    vt.push_back(mkv(1, T_SYS,   3'b001, C_CSRRW,  32'h3C,  12,  0, 13, 0, 0,  0,  1, C_CSRRW,  32'h3C,  12,  0, 13));
    vt.push_back(mkv(1, T_LOAD,  3'b010, C_LW,     32'h40,   1,  0,  5, 0, 0,  0,  1, C_LW,     32'h40,   1,  0,  5));  // lw x5
    vt.push_back(mkv(1, T_STORE, 3'b010, C_SW,     32'h100,  1,  5,  0, 0, 0,  1,  0, Z,        32'h0,    0,  0,  0));  // sw x5: rs2 stall
    vt.push_back(mkv(1, T_STORE, 3'b010, C_SW,     32'h100,  1,  5,  0, 0, 0,  0,  1, C_SW,     32'h100,  1,  5,  0));
    vt.push_back(mkv(1, T_OP,    3'b000, C_ADD,    32'h44,   1,  2,  8, 1, 1,  0,  1, C_SW,     32'h100,  1,  5,  0));  // hold beats flush
    vt.push_back(mkv(1, T_OP,    3'b000, C_ADD,    32'h44,   1,  2,  8, 1, 1,  0,  1, C_SW,     32'h100,  1,  5,  0));
    vt.push_back(mkv(1, T_LOAD,  3'b010, C_LW,     32'h104,  1,  0,  5, 0, 0,  0,  1, C_LW,     32'h104,  1,  0,  5));  // lw x5
    vt.push_back(mkv(1, T_OP,    3'b000, C_ADD,    32'h108,  2,  5,  6, 1, 0,  0,  1, C_LW,     32'h104,  1,  0,  5));  // hold masks stall
    vt.push_back(mkv(1, T_OP,    3'b000, C_ADD,    32'h108,  2,  5,  6, 0, 0,  1,  0, Z,        32'h0,    0,  0,  0));
    vt.push_back(mkv(1, T_OP,    3'b000, C_ADD,    32'h108,  2,  5,  6, 0, 0,  0,  1, C_ADD,    32'h108,  2,  5,  6));
    vt.push_back(mkv(0, T_OP,    3'b000, C_ADD,    32'h10C,  6,  6,  7, 0, 0,  0,  0, Z,        32'h0,    0,  0,  0));  // empty ID
    vt.push_back(mkv(1, T_BRANCH,3'b000, C_BEQ,    32'h110,  3,  4,  0, 0, 0,  0,  1, C_BEQ,    32'h110,  3,  4,  0));  // beq
    vt.push_back(mkv(1, T_LOAD,  3'b010, C_LW,     32'h114,  1,  0,  4, 0, 0,  0,  1, C_LW,     32'h114,  1,  0,  4));  // lw x4
    vt.push_back(mkv(1, T_BRANCH,3'b000, C_BEQ,    32'h118,  3,  4,  0, 0, 0,  1,  0, Z,        32'h0,    0,  0,  0));  // beq x3,x4: stall
    vt.push_back(mkv(1, T_BRANCH,3'b000, C_BEQ,    32'h118,  3,  4,  0, 0, 0,  0,  1, C_BEQ,    32'h118,  3,  4,  0));
    vt.push_back(mkv(1, T_SYS,   3'b001, C_CSRRW,  32'h11C,  1,  0, 14, 0, 0,  0,  1, C_CSRRW,  32'h11C,  1,  0, 14));  // csrrw x14

    // Reset state
    drive(0, 7'd0, 3'd0, '0, 32'h0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst ex_valid", 64'(bus.ex_valid), 64'd0);
    chk("rst ex_ctrl", 64'(bus.ex_ctrl), 64'd0);
    chk("rst ex_pc", 64'(bus.ex_pc), 64'd0);
    chk("rst hz_stall", 64'(bus.hz_stall), 64'd0);
    rstn = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].vld, vt[i].op, vt[i].f3, vt[i].ctrl, vt[i].pc,
            vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].hold, vt[i].flush);
      #2;
      chk($sformatf("v%0d hz_stall", i), 64'(bus.hz_stall), 64'(vt[i].exp_stall));
      e.vld = vt[i].exp_vld; e.ctrl = vt[i].exp_ctrl; e.pc = vt[i].exp_pc;
      e.rs1 = vt[i].exp_rs1; e.rs2 = vt[i].exp_rs2; e.rd = vt[i].exp_rd; e.idx = i;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_ex();
    end

    // Reset while a CSR-use stall is pending against the csrrw x14 in EX
    drive(1, T_OP, 3'b000, C_ADD, 32'h120, 14, 0, 15, 0, 0);
    #2;
    chk("rs pre hz_stall", 64'(bus.hz_stall), 64'd1);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("rs ex_valid", 64'(bus.ex_valid), 64'd0);
    chk("rs ex_ctrl", 64'(bus.ex_ctrl), 64'd0);
    chk("rs ex_pc", 64'(bus.ex_pc), 64'd0);
    chk("rs ex_rd", 64'(bus.ex_rd), 64'd0);
    chk("rs hz_stall", 64'(bus.hz_stall), 64'd0);
    rstn = 1'b1;
    e.vld = 1'b1; e.ctrl = C_ADD; e.pc = 32'h120; e.rs1 = 14; e.rs2 = 0; e.rd = 15; e.idx = 99;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_ex();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
